// File: rtl/dlx_dram_if.sv
`default_nettype none
// ============================================================================
//  Module   : dlx_dram_if
//  Purpose  : Load/store request and response bundle between the DLX memory
//             stage (master) and the data memory responder (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface dlx_dram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dlx_dram.sv
`default_nettype none
// ============================================================================
//  Module   : dlx_dram
//  Purpose  : Word-wide data memory target for the DLX load/store port. One
//             request at a time, programmable wait states, single-cycle
//             response strobe, byte-enabled stores, alignment/range errors.
//  Revision : 1.0 - initial release
// ============================================================================
module dlx_dram #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,   // asynchronous, active low
  dlx_dram_if.slave   bus
);

  localparam int         IDX_W      = $clog2(DEPTH_WORDS);
  localparam int         LANES      = DATA_W / 8;
  localparam bit         c_zero_ws  = (WAIT_STATES == 0);
  localparam logic [3:0] c_cnt_init = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic [LANES-1:0]    r_be;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH_WORDS];

  logic                w_ready;
  logic                w_rsp_valid;
  logic                w_accept;
  logic                w_access;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_we;
  logic [LANES-1:0]    w_be;
  logic                w_err;
  logic [IDX_W-1:0]    w_idx;

  // With zero wait states the access happens on the accept edge itself, so
  // the live request fields are used; otherwise the captured copy is used.
  assign w_accept = bus.req_valid & w_ready;
  assign w_access = ((r_state == S_IDLE) & w_accept & c_zero_ws) |
                    ((r_state == S_WAIT) & (r_cnt == 4'd0));
  assign w_addr   = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
  assign w_wdata  = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;
  assign w_we     = (r_state == S_IDLE) ? bus.req_we    : r_we;
  assign w_be     = (r_state == S_IDLE) ? bus.req_be    : r_be;
  // Any set bit above the index field is out of range; no aliasing.
  assign w_err    = (w_addr[1:0] != 2'b00) | (w_addr[ADDR_W-1:IDX_W+2] != '0);
  assign w_idx    = w_addr[IDX_W+1:2];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next      = r_state;
    w_ready     = (r_state == S_IDLE) & rst;
    w_rsp_valid = (r_state == S_RESP);
    case (r_state)
      S_IDLE:  if (w_accept) w_next = c_zero_ws ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= c_cnt_init;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_we    <= bus.req_we;
        r_be    <= bus.req_be;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? '0 : r_mem[w_idx];
      end
    end
  end

  // Storage: byte-lane writes on the edge that enters RESP; never reset.
  always_ff @(posedge clk) begin
    if (w_access && w_we && !w_err) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dlx_dram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dlx_dram
//  Purpose  : Self-checking bench for dlx_dram. Three instances with 0, 1 and
//             3 wait states share clock and reset; a byte-level memory model
//             predicts every response.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dlx_dram;

  function automatic int ws_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 1 : 3;
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rv, rwe;
  logic [31:0] raddr [3];
  logic [31:0] rwdata[3];
  logic [3:0]  rbe   [3];
  wire  [2:0]  rdy, vld, err;
  wire  [31:0] rdata [3];

  int n_chk = 0;
  int n_err = 0;

  // Reference model: word contents and which bytes have been written.
  logic [31:0] mdat[3][256];
  logic [3:0]  mkn [3][256];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      dlx_dram_if u_if ();
      assign u_if.req_valid = rv[g];
      assign u_if.req_we    = rwe[g];
      assign u_if.req_addr  = raddr[g];
      assign u_if.req_wdata = rwdata[g];
      assign u_if.req_be    = rbe[g];
      assign rdy[g]   = u_if.req_ready;
      assign vld[g]   = u_if.rsp_valid;
      assign rdata[g] = u_if.rsp_rdata;
      assign err[g]   = u_if.rsp_err;
      dlx_dram #(.WAIT_STATES(ws_of(g))) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] known_mask(input int s, input int idx);
    logic [31:0] m = '0;
    for (int b = 0; b < 4; b++) if (mkn[s][idx][b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  // One full transaction on instance s with timing, handshake and data checks.
  task automatic do_req(input int s, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] got);
    int          ws = ws_of(s);
    int          to = 0;
    bit          e;
    int          idx;
    logic [31:0] m;
    got = '0;
    @(negedge clk);
    while (!rdy[s] && to < 20) begin @(negedge clk); to++; end
    if (!rdy[s]) begin chk("ready_timeout", 32'd0, 32'd1); return; end
    rv[s] = 1'b1; rwe[s] = we; raddr[s] = addr; rwdata[s] = wdata; rbe[s] = be;
    @(posedge clk); #1;
    // Fields are don't-care after acceptance: scramble them.
    rv[s] = 1'b0; rwe[s] = 1'($urandom); raddr[s] = $urandom;
    rwdata[s] = $urandom; rbe[s] = 4'($urandom);
    e   = (addr % 4 != 0) || (addr / 4 >= 256);
    idx = int'(addr / 4) % 256;
    for (int j = 0; j <= ws; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      chk("ready_busy", {31'd0, rdy[s]}, 32'd0);
      if (j < ws) chk("early_rsp", {31'd0, vld[s]}, 32'd0);
    end
    chk("rsp_valid", {31'd0, vld[s]}, 32'd1);
    chk("rsp_err", {31'd0, err[s]}, {31'd0, e});
    got = rdata[s];
    if (e || we) begin
      chk("rdata_zero", rdata[s], 32'd0);
    end else begin
      m = known_mask(s, idx);
      chk("load_data", rdata[s] & m, mdat[s][idx] & m);
    end
    if (!e && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mdat[s][idx][8*b +: 8] = wdata[8*b +: 8];
          mkn[s][idx][b] = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    chk("rsp_once", {31'd0, vld[s]}, 32'd0);
    chk("ready_back", {31'd0, rdy[s]}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int s = 0; s < 3; s++) begin
      chk({tag, "_ready"}, {31'd0, rdy[s]}, 32'd0);
      chk({tag, "_valid"}, {31'd0, vld[s]}, 32'd0);
      chk({tag, "_rdata"}, rdata[s], 32'd0);
      chk({tag, "_err"},   {31'd0, err[s]}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] prior;
    int          sel;
    logic [31:0] a;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 256; i++) begin mdat[s][i] = '0; mkn[s][i] = '0; end
      rv[s] = 1'b0; rwe[s] = 1'b0; raddr[s] = '0; rwdata[s] = '0; rbe[s] = '0;
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst = 1'b1;

    // Directed: full store, load, partial store, errors (1 wait state).
    do_req(1, 1'b1, 32'h0, $urandom, 4'hF, got);
    do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, got);
    do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, got);
    chk("load_deadbeef", got, 32'hDEADBEEF);
    do_req(1, 1'b1, 32'h10, 32'h00000055, 4'b0001, got);
    do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, got);
    chk("partial_store", got, 32'hDEADBE55);
    do_req(1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, got);
    do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, got);
    chk("be_zero_nowrite", got, 32'hDEADBE55);
    do_req(1, 1'b0, 32'h13, 32'h0, 4'h0, got);
    do_req(1, 1'b1, 32'h400, 32'h0BADF00D, 4'hF, got);
    do_req(1, 1'b0, 32'h0, 32'h0, 4'h0, got);

    // Zero wait states, req_valid held high: accept every second edge.
    do_req(0, 1'b1, 32'h0, $urandom, 4'hF, got);
    @(negedge clk);
    rv[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 32'h0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      chk("b2b_valid", {31'd0, vld[0]}, {31'd0, n[0]});
      chk("b2b_ready", {31'd0, rdy[0]}, {31'd0, ~n[0]});
      if (n[0]) chk("b2b_data", rdata[0], mdat[0][0]);
    end
    rv[0] = 1'b0;

    // Reset during WAIT on the 3-wait-state instance, with a request held
    // on the 0-wait instance throughout reset.
    prior = $urandom;
    do_req(2, 1'b1, 32'h20, prior, 4'hF, got);
    @(negedge clk);
    rv[2] = 1'b1; rwe[2] = 1'b1; raddr[2] = 32'h20; rwdata[2] = 32'h12345678; rbe[2] = 4'hF;
    @(posedge clk); #1;
    rv[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rv[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 32'h0;
    #1 chk_all_zero("mid_reset");
    repeat (3) begin
      @(posedge clk); #1;
      chk("held_ready", {31'd0, rdy[0]}, 32'd0);
      chk("held_valid", {29'd0, vld}, 32'd0);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("first_accept", {31'd0, vld[0]}, 32'd1);
    chk("first_data", rdata[0], mdat[0][0]);
    rv[0] = 1'b0;
    repeat (4) begin
      chk("aborted_rsp", {31'd0, vld[2]}, 32'd0);
      @(posedge clk); #1;
    end
    do_req(2, 1'b0, 32'h20, 32'h0, 4'h0, got);
    chk("aborted_store", got, prior);

    // Randomized traffic on all three instances.
    for (int t = 0; t < 90; t++) begin
      sel = t % 3;
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        1:       a = 32'($urandom_range(256, 300) * 4);
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      do_req(sel, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), got);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dlx_dram.md
# dlx_dram

Data memory responder for the DLX core's load/store port: accepts one word-wide read or write request at a time, waits a programmable number of cycles, then returns a single-cycle response. The datapath's memory stage is the initiator; this block is the target that completes the DLX top next to the instruction RAM.

## Interface
- DATA_W, 32: data word width. Fixed at 32; byte lanes = DATA_W/8.
- DEPTH_WORDS, 256: number of 32-bit words stored. Must be a power of two.
- ADDR_W, 32: byte address width, matching PC_SIZE.
- WAIT_STATES, 1: extra cycles between request acceptance and the memory access. Range 0..15.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- req_be  in  4  store byte enables; lane i = bits 8i+7:8i. Ignored on loads.
- req_ready  out  1  block can accept a request this cycle.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range request; qualified by rsp_valid.

## Operation
- FSM states: IDLE, WAIT, RESP.
- Handshake: a request is accepted on a rising edge where req_valid=1 and req_ready=1. req_ready = (state==IDLE) and rst=1; otherwise 0.
- Acceptance registers addr, wdata, we and be. Request inputs are don't-care after acceptance.
- Transitions:
  - IDLE -> WAIT on accept when WAIT_STATES>0; counter loads WAIT_STATES-1.
  - IDLE -> RESP on accept when WAIT_STATES=0.
  - WAIT decrements the counter. When the counter is 0: WAIT -> RESP.
  - RESP -> IDLE unconditionally. There is no response back-pressure; the core must take rsp_valid in that cycle.
- Memory access happens on the edge that enters RESP.
  - Store: write only the lanes with be=1; be=4'b0000 writes nothing and still responds.
  - Load: register the full word into rsp_rdata.
- Error: addr[1:0]!=0, or word index addr[ADDR_W-1:2] >= DEPTH_WORDS.
  - No write is performed; rsp_rdata=0, rsp_err=1.
  - Latency is the same as a normal access.
- Word index = addr[log2(DEPTH_WORDS)+1:2] after the range check. No wrap-around aliasing.
- Storage contents are not affected by reset and are undefined until written.

## Timing
- Reset (rst low, asynchronous): state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
- First acceptance is possible on the first rising edge with rst high.
- For a request accepted on edge k, rsp_valid is high for exactly the cycle following edge k+WAIT_STATES.
- One request per WAIT_STATES+2 cycles; req_ready is low during WAIT and RESP.
- A load that follows a store to the same word returns the stored data, merged per byte enables.
- Reset asserted mid-operation (WAIT or RESP):
  - returns to IDLE immediately and drops rsp_valid;
  - a store not yet committed (still in WAIT) is discarded;
  - a store already committed stays in memory.
- rsp_rdata and rsp_err hold their values until the next response; they are valid only with rsp_valid.

## Test plan
- WAIT_STATES=1. Store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10.
  - Required: each rsp_valid comes 2 cycles after its accept edge.
  - Required: load returns 0xDEADBEEF with rsp_err=0.
  - Required: req_ready is low for 2 cycles after each accept.
- Partial store. With 0xDEADBEEF at 0x10, store 0x00000055 with be 4'b0001, then load 0x10.
  - Required: 0xDEADBE55.
- Errors. Load 0x13 (misaligned), then store to 0x400 with DEPTH_WORDS=256.
  - Required: rsp_err=1 and rsp_rdata=0 for both.
  - Required: a following load of word 0 is unchanged.
- WAIT_STATES=0, back-to-back requests with req_valid held high.
  - Required: accepts on every second edge.
  - Required: rsp_valid in the cycle after each accept.
- Reset during WAIT (WAIT_STATES=3). Store 0x12345678 to 0x20, assert rst one cycle after accept, release, then load 0x20.
  - Required: no rsp_valid for the aborted store.
  - Required: the load returns the prior contents of 0x20.
  - Required: all outputs are 0 during reset.
- Requests held while rst low.
  - Required: req_ready=0 and no acceptance.
  - Required: the first accept occurs on the first edge after release.
